// File: rtl/pin_share_arbiter_pkg.sv
// pin_share_arbiter_pkg
// Shared types and helpers for the pin-sharing arbiter slice.
//   state_t    : arbiter FSM state (IDLE, GRANT, RELEASE)
//   LEVEL_HIGH : constant high pin level
//   LEVEL_LOW  : constant low pin level
//   clog2      : ceiling log2, never less than 1, for sizing counters/indices
package pin_share_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic LEVEL_HIGH = 1'b1;
  localparam logic LEVEL_LOW  = 1'b0;

  // A width of 0 is never legal, so the result is clamped to at least 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pin_share_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin picker: starting the search at index ptr and
// wrapping modulo N, it returns the first requester that is asserted.
//   req   : per-requester request bits
//   ptr   : index that has highest priority this cycle
//   valid : at least one request is present
//   pick  : one-hot of the winner (zero when !valid)
//   idx   : binary index of the winner (zero when !valid)
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [N-1:0]  pick,
  output logic [PW-1:0] idx
);

  // Walk distances 0..N-1 from ptr; the first hit wins and blocks the rest.
  always_comb begin
    int j;
    j     = 0;
    valid = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!valid && req[j]) begin
        valid   = 1'b1;
        pick[j] = 1'b1;
        idx     = PW'(j);
      end
    end
  end

endmodule

// File: rtl/pin_share_arbiter.sv
// pin_share_arbiter
// Round-robin owner of one shared output pin. The granted requester's level
// is driven onto the pin one cycle later; otherwise the pin sits at
// IDLE_LEVEL. Grants are held at least MIN_HOLD cycles and, when MAX_HOLD is
// nonzero, an owner is preempted after MAX_HOLD cycles if someone else waits.
// Every grant is followed by exactly one RELEASE cycle with gnt=0.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   req  : per-requester ownership request (level)
//   lvl  : per-requester desired pin level
//   gnt  : registered one-hot grant
//   out  : registered shared pin level
//   busy : high while in GRANT
module pin_share_arbiter
  import pin_share_arbiter_pkg::*;
#(
  parameter int   N          = 4,
  parameter int   MIN_HOLD   = 2,
  parameter int   MAX_HOLD   = 8,
  parameter logic IDLE_LEVEL = LEVEL_LOW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] lvl,
  output logic [N-1:0] gnt,
  output logic         out,
  output logic         busy
);

  localparam int HOLD_TOP = (MAX_HOLD > MIN_HOLD) ? MAX_HOLD : MIN_HOLD;
  localparam int PW       = clog2(N);
  localparam int CW       = clog2(HOLD_TOP + 1);

  localparam logic [CW-1:0] CNT_MAX  = CW'(HOLD_TOP);
  localparam logic [CW-1:0] MIN_LIM  = CW'(MIN_HOLD - 1);
  localparam logic [CW-1:0] MAX_LIM  = CW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(N - 1);

  state_t        state, state_next;
  logic [N-1:0]  gnt_next;
  logic          out_next;
  logic [PW-1:0] owner, owner_next;
  logic [PW-1:0] ptr, ptr_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          pick_valid;
  logic [N-1:0]  pick_onehot;
  logic [PW-1:0] pick_idx;
  logic          others_pending;
  logic          release_now;

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .pick  (pick_onehot),
    .idx   (pick_idx)
  );

  assign busy = (state == GRANT);

  // While granted, gnt is exactly onehot(owner), so masking it out of req
  // leaves only the competing requesters.
  always_comb begin
    others_pending = |(req & ~gnt);
    release_now    = (!req[owner] && (cnt >= MIN_LIM)) ||
                     ((MAX_HOLD != 0) && (cnt >= MAX_LIM) && others_pending);
  end

  // State register together with the registered outputs and datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      out   <= IDLE_LEVEL;
      owner <= '0;
      cnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_next;
      gnt   <= gnt_next;
      out   <= out_next;
      owner <= owner_next;
      cnt   <= cnt_next;
      ptr   <= ptr_next;
    end
  end

  // RELEASE arbitrates like IDLE; its only job is to force the one-cycle gap.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, RELEASE: state_next = pick_valid ? GRANT : IDLE;
      GRANT:         state_next = release_now ? RELEASE : GRANT;
      default:       state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs. ptr only moves on release, so a
  // requester regranted from RELEASE still competes from the advanced ptr.
  always_comb begin
    gnt_next   = gnt;
    out_next   = IDLE_LEVEL;
    owner_next = owner;
    cnt_next   = cnt;
    ptr_next   = ptr;
    case (state)
      IDLE, RELEASE: begin
        gnt_next = pick_valid ? pick_onehot : '0;
        if (pick_valid) begin
          owner_next = pick_idx;
          cnt_next   = '0;
        end
      end
      GRANT: begin
        out_next = lvl[owner];
        cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        if (release_now) begin
          gnt_next = '0;
          ptr_next = (owner == PTR_LAST) ? '0 : owner + 1'b1;
        end
      end
      default: begin
        gnt_next = '0;
      end
    endcase
  end

endmodule

// File: doc/pin_share_arbiter.md
Name: pin_share_arbiter

Overview:
Round-robin arbiter that shares one physical output pin between N requesters. Each requester supplies a logic level. The granted requester's level is driven onto the pin, and a constant idle level is driven whenever no requester owns it. The block sits between the per-function level generators (constant drivers, inverters, pattern logic) and the top-level output pin. It enforces a minimum ownership time and optional preemption so requesters cannot starve one another.

Parameters:
N, 4, number of requesters (2..8)
MIN_HOLD, 2, minimum cycles a grant is held once issued (>=1)
MAX_HOLD, 8, cycles after which an owner is preempted if another requester is pending; 0 disables preemption; otherwise must be >=MIN_HOLD
IDLE_LEVEL, 1'b0, pin level when no grant is active

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
req  input  N  per-requester ownership request, level-sensitive
lvl  input  N  per-requester desired pin level
gnt  output N  one-hot grant, registered
out  output 1  shared pin level, registered
busy output 1  high while in GRANT

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, gnt=0, out=IDLE_LEVEL, busy=0, ptr=0, cnt=0. Reset has priority over all other events, including mid-grant.
- State machine:
  - States: IDLE, GRANT, RELEASE (encoding from package).
  - IDLE: gnt=0, out<=IDLE_LEVEL. If any req, select the winner by round-robin from ptr. Next cycle: state=GRANT, gnt=onehot(winner), owner=winner, cnt=0.
  - GRANT: busy=1, out<=lvl[owner] every cycle, so out lags lvl by 1 cycle. cnt increments and saturates at max(MIN_HOLD, MAX_HOLD).
  - Release condition, evaluated each GRANT cycle:
    - (a) req[owner]==0 and cnt>=MIN_HOLD-1; or
    - (b) MAX_HOLD!=0 and cnt>=MAX_HOLD-1 and any req[i], i!=owner.
  - On release: next state=RELEASE, gnt=0, ptr=(owner+1) mod N.
  - RELEASE: gnt=0, out<=IDLE_LEVEL (so out shows the last owner's level for exactly one cycle after gnt drops, then IDLE_LEVEL). Arbitrates exactly like IDLE: if any req, next state=GRANT with the new winner; else IDLE. The guaranteed gap between grants is exactly one cycle with gnt=0.
- Round-robin rule: winner is the lowest index i such that req[(ptr+i) mod N]==1. ptr advances only on release, never on grant.
- Boundary conditions:
  - Owner drops req before MIN_HOLD: grant held until cnt==MIN_HOLD-1, out keeps tracking lvl[owner].
  - Lone requester never preempted: condition (b) requires another pending req.
  - Owner re-asserting req in the RELEASE cycle does not win over lower-distance requesters. If it is the only requester, it is regranted after one gap cycle.
  - Simultaneous requests in the same cycle are resolved purely by ptr.
  - lvl of non-owners is ignored.
  - gnt is always one-hot or zero; never more than one bit set.
  - cnt width is clog2(max(MIN_HOLD, MAX_HOLD)+1); no wrap.

Decomposition:
- Shared package:
  - state enum {IDLE, GRANT, RELEASE}
  - level constants LEVEL_HIGH=1'b1 and LEVEL_LOW=1'b0, used for IDLE_LEVEL
  - a clog2 helper
- Sub-module `rr_pick`: combinational round-robin picker. Inputs req[N] and ptr. Outputs valid and a one-hot pick plus its index. The arbiter FSM instantiates it once.

Test Plan (N=4, MIN_HOLD=2, MAX_HOLD=8, IDLE_LEVEL=0):
1. Reset: rst=1 for 2 cycles with req=4'b1111, lvl=4'b1111 -> gnt=0, out=0, busy=0 throughout. First grant after rst falls is gnt=4'b0001.
2. Single owner: req=4'b0100 rises at cycle 0, lvl[2]=1 -> gnt=4'b0100 and busy=1 at cycle 1, out=1 at cycle 2. Drop req at cycle 6 -> gnt=0 at cycle 7, out=1 at 7, out=0 at 8.
3. Round robin: req=4'b1111 held constantly -> grants cycle 0001,0010,0100,1000,0001. Each lasts 8 cycles, separated by one gnt=0 cycle.
4. Minimum hold: req[1] pulsed for 1 cycle -> gnt=4'b0010 for exactly 2 cycles, then 1 RELEASE cycle, then IDLE.
5. No preemption when alone: req=4'b0001 held 20 cycles -> gnt=4'b0001 continuous, no gap. Raise req[3] at cycle 12 -> gnt=0 next cycle, then gnt=4'b1000.
6. Reset mid-grant: rst=1 for one cycle while gnt=4'b0100 -> next cycle gnt=0, out=0, ptr=0. With req=4'b1111 afterwards, gnt=4'b0001 follows.
